// File: rtl/fetch_buffer_if.sv
// Bus between the instruction prefetch queue, InstructionMemory and the IF/ID stage.
// The master side is the fetch buffer. The slave side is the memory/decode environment.
interface fetch_buffer_if #(
  parameter int DEPTH = 4
);
  logic [31:0]            imem_addr;
  logic [31:0]            imem_data;
  logic                   stall;
  logic                   redirect;
  logic [31:0]            redirect_pc;
  logic                   inst_valid;
  logic [31:0]            inst;
  logic [31:0]            inst_pc;
  logic [31:0]            inst_pc4;
  logic [$clog2(DEPTH):0] count;

  modport master (
    output imem_addr, inst_valid, inst, inst_pc, inst_pc4, count,
    input  imem_data, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_addr, inst_valid, inst, inst_pc, inst_pc4, count,
    output imem_data, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction prefetch queue. It owns the fetch PC and buffers {inst, pc, pc+4} so that ID stalls lose no fetches.
// A redirect from EX flushes every queued entry and restarts fetch at the word-aligned target.
module fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter logic [31:0] NOP      = 32'h00000013
) (
  input  logic            clk,
  input  logic            reset,
  fetch_buffer_if.master  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   r_fetchPc;
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;

  logic [31:0] r_instMem [DEPTH];
  logic [31:0] r_pcMem   [DEPTH];
  logic [31:0] r_pc4Mem  [DEPTH];

  logic        w_full;
  logic        w_valid;
  logic        w_pop;
  logic        w_push;
  logic [31:0] w_fetchPc4;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_valid    = (r_count != '0);
  assign w_pop      = w_valid & ~bus.stall & ~bus.redirect;
  // A full queue can still accept a fetch when the head leaves in the same cycle.
  assign w_push     = ~bus.redirect & (~w_full | w_pop);
  assign w_fetchPc4 = r_fetchPc + 32'd4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetchPc <= RESET_PC;
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_count   <= '0;
    end else if (bus.redirect) begin
      r_fetchPc <= {bus.redirect_pc[31:2], 2'b00};
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_count   <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr   <= r_wrPtr + PW'(1);
        r_fetchPc <= w_fetchPc4;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Storage is deliberately left out of reset; entries are only observed through inst_valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instMem[r_wrPtr] <= bus.imem_data;
      r_pcMem[r_wrPtr]   <= r_fetchPc;
      r_pc4Mem[r_wrPtr]  <= w_fetchPc4;
    end
  end

  assign bus.imem_addr  = r_fetchPc;
  assign bus.count      = r_count;
  assign bus.inst_valid = w_valid;
  assign bus.inst       = w_valid ? r_instMem[r_rdPtr] : NOP;
  assign bus.inst_pc    = w_valid ? r_pcMem[r_rdPtr]   : 32'd0;
  assign bus.inst_pc4   = w_valid ? r_pc4Mem[r_rdPtr]  : 32'd0;

endmodule
